// File: rtl/message_slicer_if.sv
// Message bus between a wide-message producer and the slicer.
//   in_data  : one whole message; the top WDTH bits are slice 0 (the header)
//   in_nd    : in_data is valid this cycle; each high cycle is a separate message
//   out_data : current output slice
//   out_nd   : out_data is valid this cycle
//   error    : sticky overflow flag
// The master modport drives messages in. The slave modport is the slicer side.
interface message_slicer_if #(
  parameter int unsigned N_SLICES = 2,
  parameter int unsigned WDTH     = 32
);
  logic [WDTH*N_SLICES-1:0] in_data;
  logic                     in_nd;
  logic [WDTH-1:0]          out_data;
  logic                     out_nd;
  logic                     error;

  modport master (
    output in_data,
    output in_nd,
    input  out_data,
    input  out_nd,
    input  error
  );

  modport slave (
    input  in_data,
    input  in_nd,
    output out_data,
    output out_nd,
    output error
  );
endinterface

// File: rtl/message_slicer.sv
// Serialises wide messages into a stream of WDTH-bit words, most-significant slice first.
// Messages are queued in a FIFO that holds BUFFER_LENGTH whole messages. The head entry
// is emitted one slice per clock. Back-to-back entries stream with no idle cycle between them.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; clears the FIFO, the outputs and error
//   msg_io : slave side of message_slicer_if (in_data/in_nd in, out_data/out_nd/error out)
module message_slicer #(
  parameter int unsigned N_SLICES          = 2,
  parameter int unsigned WDTH              = 32,
  parameter int unsigned BUFFER_LENGTH     = 8,
  parameter int unsigned LOG_BUFFER_LENGTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  message_slicer_if.slave   msg_io
);

  localparam int unsigned MsgW   = WDTH * N_SLICES;
  localparam int unsigned SliceW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam int unsigned PtrW   = LOG_BUFFER_LENGTH;
  localparam int unsigned CntW   = LOG_BUFFER_LENGTH + 1;

  localparam logic [SliceW-1:0] LastSlice = SliceW'(N_SLICES - 1);
  localparam logic [CntW-1:0]   FullCnt   = CntW'(BUFFER_LENGTH);

  logic [MsgW-1:0]   mem_q [BUFFER_LENGTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SliceW-1:0] slice_q, slice_d;
  logic [WDTH-1:0]   out_data_q, out_data_d;
  logic              out_nd_q, out_nd_d;
  logic              error_q, error_d;

  logic              empty, full, emit, pop, push, overflow;
  logic [WDTH-1:0]   head_slices [N_SLICES];

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FullCnt);
  assign emit     = !empty;
  assign pop      = emit && (slice_q == LastSlice);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
  assign push     = msg_io.in_nd && (!full || pop);
  assign overflow = msg_io.in_nd && full && !pop;

  // Split the head entry so slice k is the k-th word counted from the MS end.
  always_comb begin
    for (int k = 0; k < N_SLICES; k++) begin
      head_slices[k] = mem_q[rd_ptr_q][WDTH*(N_SLICES-k)-1 -: WDTH];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    slice_d    = slice_q;
    out_data_d = out_data_q;
    out_nd_d   = 1'b0;
    error_d    = error_q | overflow;

    if (emit) begin
      out_data_d = head_slices[slice_q];
      out_nd_d   = 1'b1;
      if (pop) begin
        slice_d  = '0;
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
        slice_d  = slice_q + SliceW'(1);
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end

    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      slice_q    <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      slice_q    <= slice_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      error_q    <= error_d;
    end
  end

  // Storage needs no reset because the pointers and the count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= msg_io.in_data;
    end
  end

  assign msg_io.out_data = out_data_q;
  assign msg_io.out_nd   = out_nd_q;
  assign msg_io.error    = error_q;

endmodule

// File: tb/tb_message_slicer.sv
// Directed testbench for message_slicer. It drives inputs and samples outputs on the falling edge.
module tb_message_slicer;
  localparam int unsigned N_SLICES = 2;
  localparam int unsigned WDTH     = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] got_q[$];
  int          got_gaps;

  always #5 clk = ~clk;

  message_slicer_if #(.N_SLICES(N_SLICES), .WDTH(WDTH)) bus ();

  message_slicer #(
    .N_SLICES         (N_SLICES),
    .WDTH             (WDTH),
    .BUFFER_LENGTH    (8),
    .LOG_BUFFER_LENGTH(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .msg_io(bus)
  );

  function automatic logic [63:0] mk_msg(input int i);
    logic [15:0] t;
    t = 16'(i);
    return {16'hA5A5, t, 16'h5A5A, t};
  endfunction

  // Sends n messages on consecutive cycles, then idles. It records every valid output
  // word, and it counts idle gaps that appear between the first and the last word.
  task automatic run_stream(input int n, input int budget);
    bit started = 1'b0;
    bit seen_idle = 1'b0;
    got_q.delete();
    got_gaps = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.out_nd) begin
        if (seen_idle) got_gaps++;
        got_q.push_back(bus.out_data);
        started = 1'b1;
      end else if (started) begin
        seen_idle = 1'b1;
      end
      if (c < n) begin
        bus.in_data = mk_msg(c + 1);
        bus.in_nd   = 1'b1;
      end else begin
        bus.in_nd   = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus.in_nd   = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.out_nd !== 1'b0) begin
      fails++; $display("FAIL reset_out_nd: got %b want 0", bus.out_nd);
    end
    tests++;
    if (bus.out_data !== 32'h0) begin
      fails++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data);
    end
    tests++;
    if (bus.error !== 1'b0) begin
      fails++; $display("FAIL reset_error: got %b want 0", bus.error);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (bus.out_nd !== 1'b0) begin
        fails++; $display("FAIL reset_idle_nd[%0d]: got %b want 0", i, bus.out_nd);
      end
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    bus.in_data = 64'h0000_0401_DEAD_BEEF;
    bus.in_nd   = 1'b1;
    @(negedge clk);
    bus.in_nd   = 1'b0;
    tests++;
    if (bus.out_nd !== 1'b0) begin
      fails++; $display("FAIL single_no_bypass: got out_nd %b want 0", bus.out_nd);
    end
    @(negedge clk);
    tests++;
    if (bus.out_nd !== 1'b1 || bus.out_data !== 32'h0000_0401) begin
      fails++;
      $display("FAIL single_hi: got nd=%b data=%h want nd=1 data=00000401", bus.out_nd,
               bus.out_data);
    end
    @(negedge clk);
    tests++;
    if (bus.out_nd !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_lo: got nd=%b data=%h want nd=1 data=deadbeef", bus.out_nd,
               bus.out_data);
    end
    @(negedge clk);
    tests++;
    if (bus.out_nd !== 1'b0 || bus.out_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_idle_hold: got nd=%b data=%h want nd=0 data=deadbeef", bus.out_nd,
               bus.out_data);
    end
  endtask

  // Expected words for the listed message indices: hi then lo of each message.
  task automatic check_words(input string name, input int kept[$]);
    logic [31:0] exp_q[$];
    logic [63:0] m;
    foreach (kept[j]) begin
      m = mk_msg(kept[j]);
      exp_q.push_back(m[63:32]);
      exp_q.push_back(m[31:0]);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d words want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL %s_word[%0d]: got %h want %h", name, i, got_q[i], exp_q[i]);
      end
    end
    tests++;
    if (got_gaps != 0) begin
      fails++; $display("FAIL %s_gaps: got %0d want 0", name, got_gaps);
    end
  endtask

  task automatic test_burst;
    int kept[$];
    for (int k = 1; k <= 4; k++) kept.push_back(k);
    run_stream(4, 16);
    check_words("burst", kept);
    tests++;
    if (bus.error !== 1'b0) begin
      fails++; $display("FAIL burst_error: got %b want 0", bus.error);
    end
  endtask

  task automatic test_fill;
    int kept[$];
    for (int k = 1; k <= 9; k++) kept.push_back(k);
    run_stream(9, 28);
    check_words("fill", kept);
    tests++;
    if (bus.error !== 1'b0) begin
      fails++; $display("FAIL fill_error: got %b want 0", bus.error);
    end
  endtask

  // The drain frees one slot every two cycles. The FIFO fills at message 14,
  // so messages 16, 18 and 20 arrive with no pop and are dropped.
  task automatic test_overflow;
    int kept[$];
    for (int k = 1; k <= 15; k++) kept.push_back(k);
    kept.push_back(17);
    kept.push_back(19);
    run_stream(20, 48);
    check_words("overflow", kept);
    tests++;
    if (bus.error !== 1'b1) begin
      fails++; $display("FAIL overflow_error: got %b want 1", bus.error);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (bus.error !== 1'b1) begin
      fails++; $display("FAIL overflow_sticky: got %b want 1", bus.error);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.error !== 1'b0) begin
      fails++; $display("FAIL overflow_reset_clear: got %b want 0", bus.error);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus.in_data = 64'h1111_2222_3333_4444;
    bus.in_nd   = 1'b1;
    @(negedge clk);
    bus.in_nd   = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.out_nd !== 1'b1 || bus.out_data !== 32'h1111_2222) begin
      fails++;
      $display("FAIL async_hi: got nd=%b data=%h want nd=1 data=11112222", bus.out_nd,
               bus.out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_nd !== 1'b0 || bus.out_data !== 32'h0) begin
      fails++;
      $display("FAIL async_immediate: got nd=%b data=%h want nd=0 data=00000000", bus.out_nd,
               bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (bus.out_nd !== 1'b0) begin
        fails++;
        $display("FAIL async_no_tail[%0d]: got nd=%b data=%h want nd=0", i, bus.out_nd,
                 bus.out_data);
      end
    end
  endtask

  initial begin
    bus.in_nd   = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
